// File: rtl/split_seq_if.sv
// Stream interface for split_seq: sample input handshake plus the even/odd pair
// output handshake. The design side uses the slave modport.
interface split_seq_if #(
  parameter int unsigned SIZE = 8
);
  localparam int unsigned IDX_W = (SIZE > 2) ? $clog2(SIZE / 2) : 1;

  logic [32:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [32:0]      even_data;
  logic [32:0]      odd_data;
  logic [IDX_W-1:0] pair_idx;
  logic             pair_valid;
  logic             pair_last;
  logic             pair_ready;
  logic             busy;
  logic             frame_err;

  modport master (
    output in_data, in_valid, in_last, pair_ready,
    input  in_ready, even_data, odd_data, pair_idx, pair_valid, pair_last,
           busy, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, pair_ready,
    output in_ready, even_data, odd_data, pair_idx, pair_valid, pair_last,
           busy, frame_err
  );
endinterface

// File: rtl/split_seq.sv
// Frame sequencer: buffers SIZE samples, then issues them as SIZE/2 even/odd pairs.
// Optional framing check on in_last enabled by defining SPLIT_SEQ_LAST_CHECK_EN.
module split_seq #(
  parameter int unsigned SIZE = 8
) (
  input logic        clk,
  input logic        rst,
  split_seq_if.slave ifc
);
  localparam int unsigned WR_W  = $clog2(SIZE);
  localparam int unsigned IDX_W = (SIZE > 2) ? $clog2(SIZE / 2) : 1;
  localparam logic [WR_W-1:0]  WR_LAST = WR_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(SIZE / 2 - 1);

  typedef enum logic {
    LOAD,
    EMIT
  } state_e;

  state_e           state_q, state_d;
  logic [WR_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             frame_err_q, frame_err_d;
  logic [32:0]      mem_q [SIZE];
  logic             wr_en;
  logic             bad_frame;
  logic [WR_W-1:0]  even_addr;
  logic [WR_W-1:0]  odd_addr;
  logic             pair_vld;

`ifdef SPLIT_SEQ_LAST_CHECK_EN
  assign bad_frame = ifc.in_last != (wr_idx_q == WR_LAST);
`else
  logic unused_last;
  assign unused_last = ifc.in_last;
  assign bad_frame   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      LOAD: begin
        if (ifc.in_valid) begin
          if (bad_frame) begin
            // Misframed sample: drop it together with the partial frame.
            wr_idx_d    = '0;
            frame_err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (wr_idx_q == WR_LAST) begin
              wr_idx_d = '0;
              state_d  = EMIT;
            end else begin
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
      end
      EMIT: begin
        if (ifc.pair_ready) begin
          if (rd_idx_q == RD_LAST) begin
            rd_idx_d = '0;
            state_d  = LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Buffer has no reset; stale contents are never visible before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_idx_q] <= ifc.in_data;
    end
  end

  assign pair_vld  = (state_q == EMIT);
  assign even_addr = WR_W'({rd_idx_q, 1'b0});
  assign odd_addr  = even_addr | WR_W'(1);

  assign ifc.in_ready   = (state_q == LOAD) && !rst;
  assign ifc.pair_valid = pair_vld;
  assign ifc.busy       = pair_vld;
  assign ifc.even_data  = pair_vld ? mem_q[even_addr] : '0;
  assign ifc.odd_data   = pair_vld ? mem_q[odd_addr] : '0;
  assign ifc.pair_idx   = pair_vld ? rd_idx_q : '0;
  assign ifc.pair_last  = pair_vld && (rd_idx_q == RD_LAST);
  assign ifc.frame_err  = frame_err_q;
endmodule

// File: tb/tb_split_seq.sv
// Directed self-checking bench for split_seq (SIZE=8 and SIZE=2 instances).
module tb_split_seq;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  split_seq_if #(.SIZE(8)) ifc ();
  split_seq_if #(.SIZE(2)) ifc2 ();

  split_seq #(.SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .ifc (ifc.slave)
  );

  split_seq #(.SIZE(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .ifc (ifc2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [32:0] d, input logic last);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = last;
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic load_frame(input int unsigned base);
    for (int i = 0; i < 8; i++) begin
      send(33'(base + i), i == 7);
    end
  endtask

  task automatic chk_pair(input int unsigned k, input int unsigned e, input int unsigned o);
    chk("pair_valid", 64'(ifc.pair_valid), 64'd1);
    chk("busy", 64'(ifc.busy), 64'd1);
    chk("in_ready_emit", 64'(ifc.in_ready), 64'd0);
    chk("even_data", 64'(ifc.even_data), 64'(e));
    chk("odd_data", 64'(ifc.odd_data), 64'(o));
    chk("pair_idx", 64'(ifc.pair_idx), 64'(k));
    chk("pair_last", 64'(ifc.pair_last), 64'(k == 3));
  endtask

  task automatic drain(input int unsigned base);
    ifc.pair_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_pair(k, base + 2 * k, base + 2 * k + 1);
      tick();
    end
    chk("drain_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("drain_valid", 64'(ifc.pair_valid), 64'd0);
    chk("drain_even0", 64'(ifc.even_data), 64'd0);
    chk("drain_last0", 64'(ifc.pair_last), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    ifc.in_data     = '0;
    ifc.in_valid    = 1'b0;
    ifc.in_last     = 1'b0;
    ifc.pair_ready  = 1'b0;
    ifc2.in_data    = '0;
    ifc2.in_valid   = 1'b0;
    ifc2.in_last    = 1'b0;
    ifc2.pair_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("rst_valid", 64'(ifc.pair_valid), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_err", 64'(ifc.frame_err), 64'd0);
    chk("rst_even", 64'(ifc.even_data), 64'd0);
    chk("rst_idx", 64'(ifc.pair_idx), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(ifc.in_ready), 64'd1);

    // Frame 0..7 back-to-back, pair_ready held high
    ifc.pair_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(33'(i), i == 7);
      chk("latency_valid", 64'(ifc.pair_valid), 64'(i == 7));
    end
    drain(0);

    // Backpressure: each pair held for two stalled cycles
    load_frame(20);
    for (int k = 0; k < 4; k++) begin
      ifc.pair_ready = 1'b0;
      chk_pair(k, 20 + 2 * k, 21 + 2 * k);
      tick();
      chk_pair(k, 20 + 2 * k, 21 + 2 * k);
      tick();
      chk_pair(k, 20 + 2 * k, 21 + 2 * k);
      ifc.pair_ready = 1'b1;
      tick();
    end
    chk("bp_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("bp_valid", 64'(ifc.pair_valid), 64'd0);

    // Sample offered during EMIT must be refused
    load_frame(30);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 33'd99;
    #1;
    chk("emit_refuse", 64'(ifc.in_ready), 64'd0);
    drain(30);
    ifc.in_valid = 1'b0;
    load_frame(40);
    drain(40);

    // Reset after second pair handshake
    load_frame(50);
    chk_pair(0, 50, 51);
    tick();
    chk_pair(1, 52, 53);
    tick();
    chk_pair(2, 54, 55);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(ifc.pair_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("mid_rst_idx", 64'(ifc.pair_idx), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(ifc.in_ready), 64'd1);
    // Frame 10..17 with an input gap after the third sample
    for (int i = 0; i < 8; i++) begin
      send(33'(10 + i), i == 7);
      if (i == 2) begin
        tick();
        tick();
        chk("gap_valid", 64'(ifc.pair_valid), 64'd0);
      end
    end
    drain(10);

`ifdef SPLIT_SEQ_LAST_CHECK_EN
    // Early in_last on 4th sample
    for (int i = 0; i < 4; i++) begin
      send(33'(70 + i), i == 3);
    end
    chk("early_err", 64'(ifc.frame_err), 64'd1);
    chk("early_valid", 64'(ifc.pair_valid), 64'd0);
    tick();
    chk("early_err_pulse", 64'(ifc.frame_err), 64'd0);
    load_frame(0);
    drain(0);
    // Missing in_last on 8th sample
    for (int i = 0; i < 8; i++) begin
      send(33'(80 + i), 1'b0);
    end
    chk("late_err", 64'(ifc.frame_err), 64'd1);
    chk("late_valid", 64'(ifc.pair_valid), 64'd0);
    chk("late_in_ready", 64'(ifc.in_ready), 64'd1);
    tick();
    chk("late_err_pulse", 64'(ifc.frame_err), 64'd0);
    load_frame(60);
    drain(60);
`else
    // in_last ignored: misplaced markers still yield a normal frame
    for (int i = 0; i < 8; i++) begin
      send(33'(60 + i), i == 3);
      chk("noerr", 64'(ifc.frame_err), 64'd0);
    end
    drain(60);
`endif

    // SIZE=2 instance: single pair per frame
    ifc2.in_valid = 1'b1;
    ifc2.in_data  = 33'h1_2345_6789;
    tick();
    ifc2.in_data  = 33'h0_DEAD_BEEF;
    ifc2.in_last  = 1'b1;
    tick();
    ifc2.in_valid = 1'b0;
    ifc2.in_last  = 1'b0;
    chk("s2_valid", 64'(ifc2.pair_valid), 64'd1);
    chk("s2_even", 64'(ifc2.even_data), 64'h1_2345_6789);
    chk("s2_odd", 64'(ifc2.odd_data), 64'h0_DEAD_BEEF);
    chk("s2_idx", 64'(ifc2.pair_idx), 64'd0);
    chk("s2_last", 64'(ifc2.pair_last), 64'd1);
    chk("s2_in_ready", 64'(ifc2.in_ready), 64'd0);
    ifc2.pair_ready = 1'b1;
    tick();
    chk("s2_done_valid", 64'(ifc2.pair_valid), 64'd0);
    chk("s2_done_in_ready", 64'(ifc2.in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/split_seq.md
# split_seq

Frame sequencer in front of the FFT radix-2 decimation stage. Collects one frame of `SIZE` 33-bit samples from a valid/ready input stream into a local buffer, then issues the frame as `SIZE/2` even/odd sample pairs (`data[2k]`, `data[2k+1]`) to the downstream butterfly over a second valid/ready handshake. Input is held off while pairs drain, so each frame is split and delivered atomically and in order.

## Interface
- `SIZE`, 8: samples per frame. Power of two, ≥2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 33: input sample.
- `in_valid` in 1: `in_data` valid.
- `in_last` in 1: marks final sample of frame; checked only under `SPLIT_SEQ_LAST_CHECK_EN`.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `even_data` out 33: `buf[2*pair_idx]`.
- `odd_data` out 33: `buf[2*pair_idx+1]`.
- `pair_idx` out max(1,$clog2(SIZE/2)): pair index k.
- `pair_valid` out 1: pair outputs valid.
- `pair_last` out 1: high with `pair_valid` when k = SIZE/2-1.
- `pair_ready` in 1: pair consumed when `pair_valid && pair_ready`.
- `busy` out 1: high in EMIT.
- `frame_err` out 1: one-cycle pulse on framing error (0 without macro).

## Operation
- States: LOAD, EMIT. Registers: `wr_idx` (0..SIZE-1), `rd_idx` (0..SIZE/2-1), buffer `buf[SIZE]`.
- LOAD: `in_ready`=1. On accept, `buf[wr_idx]`←`in_data`, `wr_idx`++. Accept at `wr_idx`=SIZE-1 → `wr_idx`←0, go EMIT.
- EMIT: `in_ready`=0, `pair_valid`=1, `busy`=1. Outputs read combinationally from buffer at `rd_idx`. On pair handshake: `rd_idx`++; handshake at `rd_idx`=SIZE/2-1 → `rd_idx`←0, go LOAD.
- `pair_valid` never drops and outputs never change while waiting on `pair_ready` (stable under backpressure).
- `even_data`, `odd_data`, `pair_idx`, `pair_last` forced to 0 when `pair_valid`=0.
- Data passes unmodified; no arithmetic, no width change.
- Buffer not cleared by reset; content is don't-care until overwritten.

## Timing
- Reset (while `rst`=1 and cycle after): state LOAD, `wr_idx`=`rd_idx`=0, `pair_valid`=0, `busy`=0, `frame_err`=0, pair outputs 0. `in_ready` is 0 while `rst`=1 and 1 from the first cycle with `rst`=0.
- Latency: first `pair_valid` in cycle after the SIZE-th accepted sample.
- Minimum frame period: SIZE load cycles + SIZE/2 emit cycles; no overlap between LOAD and EMIT.
- Final pair handshake → `in_ready`=1 next cycle.
- Reset mid-frame (either state): partial frame discarded, no further pairs issued, returns to reset state next cycle.
- Input gaps (`in_valid`=0) in LOAD: counters hold.

## Configuration
- `SPLIT_SEQ_LAST_CHECK_EN` defined: in LOAD, accepted sample with `in_last`=1 at `wr_idx`<SIZE-1, or with `in_last`=0 at `wr_idx`=SIZE-1 → that sample and the partial frame discarded, `wr_idx`←0, stay LOAD, `frame_err`=1 for exactly the next cycle.
- Not defined: `in_last` ignored, `frame_err` tied 0, frames delimited by count only.

## Test plan
- SIZE=8, feed 0..7 back-to-back, `pair_ready`=1 → pairs (0,1),(2,3),(4,5),(6,7), `pair_idx` 0..3, `pair_last` only on idx 3, `in_ready` 0 for 4 cycles then 1.
- Same frame, `pair_ready` toggling 1-0-0-1 → each pair held stable until handshake, none lost or duplicated.
- `in_valid` asserted during EMIT with sample 99 → `in_ready`=0, 99 not captured; after drain, next frame loads normally.
- `rst` pulsed after 2nd pair handshake → `pair_valid`=0 next cycle; new frame 10..17 yields (10,11)…(16,17).
- Macro on: `in_last`=1 on 4th sample → `frame_err` one-cycle pulse, no pairs; next correctly framed 0..7 emits normally. Also `in_last`=0 on 8th sample → pulse, no pairs.
- SIZE=2: feed A,B → single pair (A,B), `pair_idx`=0, `pair_last`=1.
